// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller slice: FSM state encodings,
// travel direction and default geometry/timing parameters.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_MOVE_UP   = 2'b01,
    ST_MOVE_DOWN = 2'b10,
    ST_DOOR_OPEN = 2'b11
  } elev_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } elev_dir_e;

  localparam int unsigned DEF_FLOORS        = 4;
  localparam int unsigned DEF_TRAVEL_CYCLES = 8;
  localparam int unsigned DEF_DOOR_CYCLES   = 16;

endpackage

// File: rtl/elevator_cycle_timer.sv
// Cycle counter with synchronous clear and a terminal-count strobe; wraps to
// zero on the strobe cycle.
module elevator_cycle_timer #(
  parameter int unsigned TERMINAL = 8,
  parameter int unsigned CW       = $clog2(TERMINAL)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tc_o  = en_i & (cnt_q == CW'(TERMINAL - 1));
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/elevator_request_ctrl.sv
// Call latch, position tracker and target selector feeding the elevator FSM
// its UP/DOWN/EQ/T decision inputs.
module elevator_request_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS        = DEF_FLOORS,
  parameter int unsigned FLOOR_W       = 2,
  parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  call_btn,
  input  logic               motor_up,
  input  logic               motor_down,
  input  logic               door_open,
  output logic               UP,
  output logic               DOWN,
  output logic               EQ,
  output logic               T,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic [FLOORS-1:0]  req_pending,
  output logic               fault
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

  logic [FLOORS-1:0]  req_q, req_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  elev_dir_e          dir_q, dir_d;
  logic               fault_q, fault_d;

  logic moving, idle, above, below, up_c, dn_c;
  logic travel_en, step, door_restart;

  // Returns {above, below}: whether any pending request lies above/below cur.
  function automatic logic [1:0] scan_req(input logic [FLOORS-1:0]  req,
                                          input logic [FLOOR_W-1:0] cur);
    logic ab, bl;
    ab = 1'b0;
    bl = 1'b0;
    for (int unsigned f = 0; f < FLOORS; f++) begin
      if (req[f] && (f > 32'(cur))) ab = 1'b1;
      if (req[f] && (f < 32'(cur))) bl = 1'b1;
    end
    return {ab, bl};
  endfunction

  always_comb begin
    moving         = motor_up | motor_down;
    idle           = ~moving & ~door_open;
    EQ             = moving & req_q[floor_q];
    {above, below} = scan_req(req_q, floor_q);
    if (dir_q == DIR_UP) begin
      up_c = above;
      dn_c = below & ~above;
    end else begin
      dn_c = below;
      up_c = above & ~below;
    end
    UP           = idle & up_c;
    DOWN         = idle & dn_c;
    travel_en    = (motor_up ^ motor_down) & ~EQ & ~door_open;
    door_restart = door_open & call_btn[floor_q];
  end

  elevator_cycle_timer #(.TERMINAL(TRAVEL_CYCLES)) u_travel (
    .clk   (clk),
    .reset (reset),
    .clr_i (~travel_en),
    .en_i  (travel_en),
    .tc_o  (step)
  );

  elevator_cycle_timer #(.TERMINAL(DOOR_CYCLES)) u_door (
    .clk   (clk),
    .reset (reset),
    .clr_i (~door_open | door_restart),
    .en_i  (door_open),
    .tc_o  (T)
  );

  always_comb begin
    req_d = req_q | call_btn;
    if (idle || door_open) req_d[floor_q] = req_q[floor_q];
    if (T) req_d[floor_q] = 1'b0;

    floor_d = floor_q;
    if (step) begin
      if (motor_up && (floor_q != TOP_FLOOR)) floor_d = floor_q + 1'b1;
      else if (motor_down && (floor_q != '0)) floor_d = floor_q - 1'b1;
    end

    dir_d = dir_q;
    if (motor_up) dir_d = DIR_UP;
    else if (motor_down) dir_d = DIR_DOWN;

    // End-of-shaft drive is only an error when not stopping there (EQ=0):
    // the FSM legitimately holds the motor for the arrival cycle.
    fault_d = fault_q
            | (motor_up & motor_down)
            | (motor_up & ~EQ & (floor_q == TOP_FLOOR))
            | (motor_down & ~EQ & (floor_q == '0))
            | (moving & door_open);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= '0;
      floor_q <= '0;
      dir_q   <= DIR_UP;
      fault_q <= 1'b0;
    end else begin
      req_q   <= req_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      fault_q <= fault_d;
    end
  end

  assign cur_floor   = floor_q;
  assign req_pending = req_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_elevator_request_ctrl.sv
// Closed-loop bench: request controller plus a behavioural elevator FSM,
// checked against hand-computed observation vectors.
module tb_elevator_request_ctrl;
  import elevator_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] call_btn;
  logic       motor_up, motor_down, door_open;
  logic       UP, DOWN, EQ, T, fault;
  logic [1:0] cur_floor;
  logic [3:0] req_pending;
  logic       force_mu, force_md;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       up;
    logic       dn;
    logic       eq;
    logic       t;
    logic [1:0] fl;
    logic [3:0] req;
    logic       flt;
  } obs_t;

  typedef struct {
    logic [3:0] btn;
    int         adv;
    obs_t       exp;
  } vec_t;

  vec_t tbl[$];

  elevator_request_ctrl #(
    .FLOORS        (4),
    .FLOOR_W       (2),
    .TRAVEL_CYCLES (8),
    .DOOR_CYCLES   (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .call_btn    (call_btn),
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .door_open   (door_open),
    .UP          (UP),
    .DOWN        (DOWN),
    .EQ          (EQ),
    .T           (T),
    .cur_floor   (cur_floor),
    .req_pending (req_pending),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  elev_state_e st;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= ST_IDLE;
    end else begin
      case (st)
        ST_IDLE:      if (UP) st <= ST_MOVE_UP; else if (DOWN) st <= ST_MOVE_DOWN;
        ST_MOVE_UP,
        ST_MOVE_DOWN: if (EQ) st <= ST_DOOR_OPEN;
        ST_DOOR_OPEN: if (T) st <= ST_IDLE;
        default:      st <= ST_IDLE;
      endcase
    end
  end

  assign motor_up   = (st == ST_MOVE_UP) | force_mu;
  assign motor_down = (st == ST_MOVE_DOWN) | force_md;
  assign door_open  = (st == ST_DOOR_OPEN);

  function automatic obs_t mk(input logic up, input logic dn, input logic eq,
                              input logic t, input logic [1:0] fl,
                              input logic [3:0] req);
    obs_t o;
    o = '{up: up, dn: dn, eq: eq, t: t, fl: fl, req: req, flt: 1'b0};
    return o;
  endfunction

  task automatic add(input logic [3:0] btn, input int adv, input obs_t exp);
    vec_t v;
    v.btn = btn;
    v.adv = adv;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = '{up: UP, dn: DOWN, eq: EQ, t: T, fl: cur_floor, req: req_pending, flt: fault};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {UP,DOWN,EQ,T,floor,req,fault}=%b required %b", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] btn);
    call_btn = btn;
    @(negedge clk);
    call_btn = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    obs_t flt_only;
    reset    = 1'b1;
    call_btn = '0;
    force_mu = 1'b0;
    force_md = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", '0);
    reset = 1'b0;

    // Serve floor 2 from floor 0, drop same-floor idle press, then {0,3} with dir=up.
    add(4'b0100, 1,  mk(1, 0, 0, 0, 2'd0, 4'b0100));
    add(4'b0000, 1,  mk(0, 0, 0, 0, 2'd0, 4'b0100));
    add(4'b0000, 7,  mk(0, 0, 0, 0, 2'd0, 4'b0100));
    add(4'b0000, 1,  mk(0, 0, 0, 0, 2'd1, 4'b0100));
    add(4'b0000, 8,  mk(0, 0, 1, 0, 2'd2, 4'b0100));
    add(4'b0000, 1,  mk(0, 0, 0, 0, 2'd2, 4'b0100));
    add(4'b0000, 14, mk(0, 0, 0, 0, 2'd2, 4'b0100));
    add(4'b0000, 1,  mk(0, 0, 0, 1, 2'd2, 4'b0100));
    add(4'b0000, 1,  mk(0, 0, 0, 0, 2'd2, 4'b0000));
    add(4'b0100, 1,  mk(0, 0, 0, 0, 2'd2, 4'b0000));
    add(4'b0000, 3,  mk(0, 0, 0, 0, 2'd2, 4'b0000));
    add(4'b1001, 1,  mk(1, 0, 0, 0, 2'd2, 4'b1001));
    add(4'b0000, 9,  mk(0, 0, 1, 0, 2'd3, 4'b1001));
    add(4'b0000, 16, mk(0, 0, 0, 1, 2'd3, 4'b1001));
    add(4'b0000, 1,  mk(0, 1, 0, 0, 2'd3, 4'b0001));
    add(4'b0000, 9,  mk(0, 0, 0, 0, 2'd2, 4'b0001));
    add(4'b0000, 16, mk(0, 0, 1, 0, 2'd0, 4'b0001));
    add(4'b0000, 16, mk(0, 0, 0, 1, 2'd0, 4'b0001));
    add(4'b0000, 1,  mk(0, 0, 0, 0, 2'd0, 4'b0000));

    for (int i = 0; i < tbl.size(); i++) begin
      call_btn = tbl[i].btn;
      @(negedge clk);
      call_btn = '0;
      repeat (tbl[i].adv - 1) @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Heading 0->3, intermediate press of floor 1 at travel_cnt=3.
    press(4'b1000);
    check("mid_up", mk(1, 0, 0, 0, 2'd0, 4'b1000));
    repeat (4) @(negedge clk);
    press(4'b0010);
    check("mid_latched", mk(0, 0, 0, 0, 2'd0, 4'b1010));
    repeat (4) @(negedge clk);
    check("mid_eq_fl1", mk(0, 0, 1, 0, 2'd1, 4'b1010));
    // Door restart: press own floor at door_cnt=10.
    repeat (11) @(negedge clk);
    check("door_cnt10", mk(0, 0, 0, 0, 2'd1, 4'b1010));
    press(4'b0010);
    repeat (4) @(negedge clk);
    check("no_early_T", mk(0, 0, 0, 0, 2'd1, 4'b1010));
    repeat (11) @(negedge clk);
    check("T_after_restart", mk(0, 0, 0, 1, 2'd1, 4'b1010));
    @(negedge clk);
    check("up_again", mk(1, 0, 0, 0, 2'd1, 4'b1000));
    repeat (17) @(negedge clk);
    check("top_arrival", mk(0, 0, 1, 0, 2'd3, 4'b1000));
    repeat (17) @(negedge clk);
    check("top_served", mk(0, 0, 0, 0, 2'd3, 4'b0000));

    // Reset mid-travel (travel_cnt=5, between floors 2 and 1).
    press(4'b0001);
    check("down_req", mk(0, 1, 0, 0, 2'd3, 4'b0001));
    repeat (14) @(negedge clk);
    check("pre_reset_fl2", mk(0, 0, 0, 0, 2'd2, 4'b0001));
    reset = 1'b1;
    #1;
    check("reset_mid_travel", '0);
    @(negedge clk);
    reset = 1'b0;

    flt_only     = '0;
    flt_only.flt = 1'b1;
    force_mu = 1'b1;
    force_md = 1'b1;
    @(negedge clk);
    force_mu = 1'b0;
    force_md = 1'b0;
    check("fault_set", flt_only);
    repeat (5) @(negedge clk);
    check("fault_held", flt_only);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    force_mu = 1'b1;
    @(negedge clk);
    force_mu = 1'b0;
    @(negedge clk);
    check("up_from_bottom_ok", '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
